// File: rtl/fs_accel_pool_ctrl_if.sv
// Control/handshake bundle between fs_accel_pool_ctrl (master) and the
// pixel source, pooled-output sink and fs_accel_pool datapath (slave side).
interface fs_accel_pool_ctrl_if;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic       buf_enb;
  logic       mpbuf_ld_wrn;
  logic       cp_enb;
  logic [3:0] sel_demux;
  logic [3:0] sel_mux;
  logic       cp_clr;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;

  modport master (
    input  start, in_valid, out_ready,
    output in_ready, buf_enb, mpbuf_ld_wrn, cp_enb, sel_demux, sel_mux,
           cp_clr, out_valid, busy, done
  );

  modport slave (
    output start, in_valid, out_ready,
    input  in_ready, buf_enb, mpbuf_ld_wrn, cp_enb, sel_demux, sel_mux,
           cp_clr, out_valid, busy, done
  );
endinterface

// File: rtl/fs_accel_pool_ctrl.sv
// 2x2 stride-2 max-pool sequencer: LOAD/FOLD per pixel, DRAIN after each row pair.
// Define FS_ACCEL_POOL_CTRL_OVERLAP_EN to accept a new pixel during FOLD (1 pixel/cycle).
module fs_accel_pool_ctrl #(
  parameter int IN_W = 26,
  parameter int IN_H = 26
) (
  input  logic                 clk,
  input  logic                 reset,
  fs_accel_pool_ctrl_if.master bus
);

  localparam int OUT_W  = IN_W / 2;
  localparam int COL_W  = $clog2(IN_W);
  localparam int ROW_W  = $clog2(IN_H);
  localparam int OCNT_W = $clog2(OUT_W + 1);

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IN_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IN_H - 1);
  localparam logic [OCNT_W-1:0] OCNT_LAST = OCNT_W'(OUT_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FOLD,
    S_DRAIN,
    S_CLR
  } state_t;

  state_t              state_q, state_d;
  logic [COL_W-1:0]    col_q,   col_d;
  logic [ROW_W-1:0]    row_q,   row_d;
  logic [OCNT_W-1:0]   ocnt_q,  ocnt_d;
  logic                done_q,  done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      ocnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      ocnt_q  <= ocnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    ocnt_d  = ocnt_q;
    done_d  = 1'b0;

    bus.in_ready     = 1'b0;
    bus.buf_enb      = 1'b0;
    bus.mpbuf_ld_wrn = 1'b0;
    bus.cp_enb       = 1'b0;
    bus.sel_demux    = '0;
    bus.sel_mux      = '0;
    bus.cp_clr       = 1'b0;
    bus.out_valid    = 1'b0;
    bus.busy         = (state_q != S_IDLE);
    bus.done         = done_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_LOAD;
      end

      S_LOAD: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          bus.buf_enb      = 1'b1;
          bus.mpbuf_ld_wrn = 1'b1;
          state_d          = S_FOLD;
        end
      end

      S_FOLD: begin
        bus.buf_enb   = 1'b1;
        bus.cp_enb    = 1'b1;
        bus.sel_demux = 4'(col_q >> 1);
        if (col_q == COL_LAST) begin
          col_d = '0;
          if (row_q[0]) begin
            state_d = S_DRAIN;
          end else begin
            row_d   = row_q + ROW_W'(1);
            state_d = S_LOAD;
          end
        end else begin
          col_d   = col_q + COL_W'(1);
          state_d = S_LOAD;
        end
`ifdef FS_ACCEL_POOL_CTRL_OVERLAP_EN
        // The last fold of a row pair must not accept a pixel: the comparators drain first.
        if (!(col_q == COL_LAST && row_q[0])) begin
          bus.in_ready = 1'b1;
          if (bus.in_valid) begin
            bus.mpbuf_ld_wrn = 1'b1;
            state_d          = S_FOLD;
          end
        end
`endif
      end

      S_DRAIN: begin
        bus.out_valid = 1'b1;
        bus.sel_mux   = 4'(ocnt_q);
        if (bus.out_ready) begin
          if (ocnt_q == OCNT_LAST) begin
            ocnt_d  = '0;
            state_d = S_CLR;
          end else begin
            ocnt_d = ocnt_q + OCNT_W'(1);
          end
        end
      end

      S_CLR: begin
        bus.cp_clr = 1'b1;
        if (row_q == ROW_LAST) begin
          row_d   = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          row_d   = row_q + ROW_W'(1);
          state_d = S_LOAD;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fs_accel_pool_ctrl.sv
// Bench for fs_accel_pool_ctrl: a 4x2 and a 26x4 instance share one stimulus
// driver; a per-cycle model and a datapath emulation check every cycle.
module tb_fs_accel_pool_ctrl;

  logic clk;
  logic reset;
  logic act;
  logic start;
  logic in_valid;
  logic out_ready;
  logic signed [7:0] pix;

  int n_checks = 0;
  int n_fail   = 0;

  fs_accel_pool_ctrl_if bus0();
  fs_accel_pool_ctrl_if bus1();

  // Only the selected instance sees stimulus; the other is held in reset.
  assign bus0.start     = start & ~act;
  assign bus0.in_valid  = in_valid & ~act;
  assign bus0.out_ready = out_ready & ~act;
  assign bus1.start     = start & act;
  assign bus1.in_valid  = in_valid & act;
  assign bus1.out_ready = out_ready & act;

  fs_accel_pool_ctrl #(.IN_W(4), .IN_H(2)) u_dut0 (
    .clk   (clk),
    .reset (reset | act),
    .bus   (bus0)
  );

  fs_accel_pool_ctrl #(.IN_W(26), .IN_H(4)) u_dut1 (
    .clk   (clk),
    .reset (reset | ~act),
    .bus   (bus1)
  );

  logic       o_in_ready, o_buf_enb, o_ld, o_cp_enb, o_cp_clr, o_out_valid, o_busy, o_done;
  logic [3:0] o_sel_demux, o_sel_mux;
  logic [15:0] o_vec;

  assign o_in_ready  = act ? bus1.in_ready     : bus0.in_ready;
  assign o_buf_enb   = act ? bus1.buf_enb      : bus0.buf_enb;
  assign o_ld        = act ? bus1.mpbuf_ld_wrn : bus0.mpbuf_ld_wrn;
  assign o_cp_enb    = act ? bus1.cp_enb       : bus0.cp_enb;
  assign o_sel_demux = act ? bus1.sel_demux    : bus0.sel_demux;
  assign o_sel_mux   = act ? bus1.sel_mux      : bus0.sel_mux;
  assign o_cp_clr    = act ? bus1.cp_clr       : bus0.cp_clr;
  assign o_out_valid = act ? bus1.out_valid    : bus0.out_valid;
  assign o_busy      = act ? bus1.busy         : bus0.busy;
  assign o_done      = act ? bus1.done         : bus0.done;
  assign o_vec = {o_in_ready, o_buf_enb, o_ld, o_cp_enb, o_sel_demux, o_sel_mux,
                  o_cp_clr, o_out_valid, o_busy, o_done};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at t=%0t",
               name, actual, actual, expected, expected, $time);
    end
  endtask

  // Image under test, raster order, sized for the larger instance.
  logic signed [7:0] img [104];

  // Model state: progress of the map expressed as event counts.
  bit mon_en = 0;
  bit m_active = 0;
  bit m_done_next = 0;
  int n_acc = 0, n_fold = 0, n_out = 0, n_clr = 0;
  int cyc = 0;
  bit last_xfer = 0;
  logic signed [7:0] comp [16];
  logic signed [7:0] dbuf;
  logic signed [7:0] exp_q [$];
  logic signed [7:0] got_q [$];
  int exp_total = 0;
  int map_done = 0, ov_cycles = 0, sel12_hs = 0, first_ir = -1, first_ov = -1;

  always @(negedge clk) begin
    int w, h, ow, pair_end, e_sd, e_sm;
    bit e_fold, e_ir, e_ld, e_buf, e_ov, e_clr, d;
    logic [15:0] e_vec;
    logic signed [7:0] v, m;
    cyc++;
    last_xfer = in_valid && o_in_ready;
    if (mon_en) begin
      w  = act ? 26 : 4;
      h  = act ? 4 : 2;
      ow = w / 2;
      pair_end = 2 * w * (n_clr + 1);
      e_fold = m_active && (n_acc == n_fold + 1);
      e_ir   = m_active && (n_fold == n_acc) && (n_fold < pair_end);
`ifdef FS_ACCEL_POOL_CTRL_OVERLAP_EN
      if (e_fold && n_acc < pair_end) e_ir = 1'b1;
`endif
      e_ld  = e_ir && in_valid;
      e_buf = e_fold || e_ld;
      e_sd  = e_fold ? ((n_fold % w) >> 1) : 0;
      e_ov  = m_active && (n_fold == pair_end) && (n_out < ow * (n_clr + 1));
      e_sm  = e_ov ? (n_out % ow) : 0;
      e_clr = m_active && (n_fold == pair_end) && (n_out == ow * (n_clr + 1));
      e_vec = {e_ir, e_buf, e_ld, e_fold, 4'(e_sd), 4'(e_sm), e_clr, e_ov, m_active, m_done_next};
      checkOutput("cycle", int'(o_vec), int'(e_vec));

      if (o_in_ready && first_ir < 0) first_ir = cyc;
      if (o_out_valid) begin
        ov_cycles++;
        if (first_ov < 0) first_ov = cyc;
      end
      if (o_done) map_done++;

      if (reset) begin
        m_active = 0; m_done_next = 0;
        n_acc = 0; n_fold = 0; n_out = 0; n_clr = 0;
        for (int i = 0; i < 16; i++) comp[i] = -8'sd128;
        dbuf = '0;
        exp_q.delete();
      end else begin
        d = 0;
        if (!m_active) begin
          if (start) begin
            m_active = 1;
            n_acc = 0; n_fold = 0; n_out = 0; n_clr = 0;
            exp_q.delete();
            got_q.delete();
            for (int rp = 0; rp < h / 2; rp++) begin
              for (int c = 0; c < ow; c++) begin
                m = img[2*rp*w + 2*c];
                if (img[2*rp*w + 2*c + 1] > m)     m = img[2*rp*w + 2*c + 1];
                if (img[(2*rp+1)*w + 2*c] > m)     m = img[(2*rp+1)*w + 2*c];
                if (img[(2*rp+1)*w + 2*c + 1] > m) m = img[(2*rp+1)*w + 2*c + 1];
                exp_q.push_back(m);
              end
            end
            exp_total = exp_q.size();
            map_done = 0; ov_cycles = 0; sel12_hs = 0; first_ir = -1; first_ov = -1;
          end
        end else begin
          // Datapath emulation driven by the DUT's own selects: read-before-write on the buffer.
          if (o_cp_enb && dbuf > comp[o_sel_demux]) comp[o_sel_demux] = dbuf;
          if (o_buf_enb && o_ld) dbuf = pix;
          if (o_out_valid && out_ready) begin
            v = comp[o_sel_mux];
            got_q.push_back(v);
            if (o_sel_mux == 4'd12) sel12_hs++;
            if (exp_q.size() == 0) checkOutput("pooled_extra", got_q.size(), exp_total);
            else checkOutput("pooled", int'(v), int'(exp_q.pop_front()));
          end
          if (o_cp_clr) for (int i = 0; i < 16; i++) comp[i] = -8'sd128;
          if (e_fold) n_fold++;
          if (e_ld) n_acc++;
          if (e_ov && out_ready) n_out++;
          if (e_clr) begin
            n_clr++;
            if (n_clr == h / 2) begin
              m_active = 0;
              d = 1;
            end
          end
        end
        m_done_next = d;
      end
    end
  end

  // Runs one map on the selected instance; optional stall, restart pulse or abort.
  task automatic applyStimulus(input bit vrand, input bit rrand, input int stall_first,
                               input int restart_at, input int abort_at);
    int p, n, budget, stall_left;
    bit restarted, fin;
    n = act ? 104 : 8;
    p = 0; budget = 0; stall_left = stall_first; restarted = 0; fin = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (!fin && budget < 6000) begin
      if (last_xfer) p++;
      if (o_done) begin
        fin = 1;
      end else if (abort_at >= 0 && p == abort_at + 1 && o_cp_enb) begin
        in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("abort_outputs", int'(o_vec), 0);
        checkOutput("abort_busy", int'(o_busy), 0);
        reset = 1'b0;
        fin = 1;
      end else begin
        in_valid = (p < n) && (!vrand || $urandom_range(0, 3) != 0);
        pix = (p < n) ? img[p] : 8'sd0;
        if (o_out_valid && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = !rrand || ($urandom_range(0, 2) != 0);
        end
        start = 1'b0;
        if (restart_at >= 0 && !restarted && p == restart_at) begin
          start = 1'b1;
          restarted = 1;
        end
        @(posedge clk); #1;
        budget++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
    if (!fin) checkOutput("stim_timeout", budget, 5999);
    repeat (3) @(negedge clk);
  endtask

  task automatic loadSmallImage();
    img[0] = 8'sd1; img[1] = 8'sd5; img[2] = -8'sd3; img[3] = 8'sd2;
    img[4] = 8'sd4; img[5] = 8'sd0; img[6] = 8'sd7;  img[7] = -8'sd8;
  endtask

  initial begin
    int bad;
    reset = 1'b1; act = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; pix = '0;
    for (int i = 0; i < 104; i++) img[i] = '0;
    repeat (2) @(posedge clk);
    #1 mon_en = 1;
    checkOutput("reset_outputs", int'(o_vec), 0);
    checkOutput("reset_busy", int'(o_busy), 0);
    @(posedge clk); #1 reset = 1'b0;

    $display("[TB] 4x2 map, continuous handshakes");
    loadSmallImage();
    applyStimulus(0, 0, 0, -1, -1);
    checkOutput("t1_count", got_q.size(), 2);
    checkOutput("t1_out0", int'(got_q[0]), 5);
    checkOutput("t1_out1", int'(got_q[1]), 7);
    checkOutput("t1_done", map_done, 1);
    checkOutput("t1_ov_cycles", ov_cycles, 2);
`ifndef FS_ACCEL_POOL_CTRL_OVERLAP_EN
    checkOutput("t1_latency", first_ov - first_ir, 16);
`endif

    $display("[TB] 4x2 map, out_ready low 3 cycles on first output");
    applyStimulus(0, 0, 3, -1, -1);
    checkOutput("t2_out0", int'(got_q[0]), 5);
    checkOutput("t2_out1", int'(got_q[1]), 7);
    checkOutput("t2_ov_cycles", ov_cycles, 5);
    checkOutput("t2_done", map_done, 1);

    $display("[TB] 4x2 map, reset in fold of pixel 3, then restart");
    applyStimulus(0, 0, 0, -1, 3);
    applyStimulus(0, 0, 0, -1, -1);
    checkOutput("t5_out0", int'(got_q[0]), 5);
    checkOutput("t5_out1", int'(got_q[1]), 7);
    checkOutput("t5_done", map_done, 1);

    $display("[TB] 4x2 maps, random images and handshakes");
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 8; i++) img[i] = $signed(8'($urandom_range(0, 255)));
      applyStimulus(1, 1, 0, -1, -1);
      checkOutput("rnd_small_count", got_q.size(), 2);
      checkOutput("rnd_small_done", map_done, 1);
    end

    reset = 1'b1;
    @(posedge clk); #1 act = 1'b1;
    @(posedge clk); #1 reset = 1'b0;

    $display("[TB] 26x4 map, single 127 at (3,25)");
    for (int i = 0; i < 104; i++) img[i] = -8'sd128;
    img[103] = 8'sd127;
    applyStimulus(1, 1, 0, -1, -1);
    checkOutput("t3_count", got_q.size(), 26);
    checkOutput("t3_out25", int'(got_q[25]), 127);
    bad = 0;
    for (int i = 0; i < got_q.size(); i++)
      if (i != 25 && got_q[i] != -8'sd128) bad++;
    checkOutput("t3_others", bad, 0);
    checkOutput("t3_sel12", sel12_hs, 2);
    checkOutput("t3_done", map_done, 1);

    $display("[TB] 26x4 map, random image, start pulsed mid-map");
    for (int i = 0; i < 104; i++) img[i] = $signed(8'($urandom_range(0, 255)));
    applyStimulus(1, 1, 0, 30, -1);
    checkOutput("t4_count", got_q.size(), 26);
    checkOutput("t4_done", map_done, 1);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
